// File: rtl/vx_branch_resolver_pkg.sv
// Shared types and default sizing for the branch resolver: per-warp state encoding,
// PC and perf-counter widths. Pure declarations; no latency or flow control.
package vx_branch_resolver_pkg;

    localparam int DEF_NUM_BLOCKS = 2;
    localparam int DEF_NUM_WARPS  = 8;
    localparam int PC_BITS        = 32;
    localparam int PERF_CTR_BITS  = 16;
    localparam int BR_STATE_BITS  = 2;

    typedef enum logic [BR_STATE_BITS-1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } br_state_t;

    function automatic int nw_width(input int num_warps);
        return (num_warps > 1) ? $clog2(num_warps) : 1;
    endfunction

endpackage

// File: rtl/vx_branch_resolver_if.sv
// Bundle of ALU branch reports, issue notifications and the scheduler PC-update
// valid/ready handshake; reports and issues carry no ready and are never stalled.
interface vx_branch_resolver_if
    import vx_branch_resolver_pkg::*;
#(
    parameter int NUM_BLOCKS = DEF_NUM_BLOCKS,
    parameter int NUM_WARPS  = DEF_NUM_WARPS
);
    localparam int NW_WIDTH = nw_width(NUM_WARPS);

    logic [NUM_BLOCKS-1:0]                br_valid_in;
    logic [NUM_BLOCKS-1:0][NW_WIDTH-1:0]  br_wid_in;
    logic [NUM_BLOCKS-1:0]                br_taken_in;
    logic [NUM_BLOCKS-1:0][PC_BITS-1:0]   br_dest_in;
    logic                                 issue_valid;
    logic [NW_WIDTH-1:0]                  issue_wid;
    logic [NUM_WARPS-1:0]                 stalled_mask;
    logic                                 upd_valid;
    logic [NW_WIDTH-1:0]                  upd_wid;
    logic                                 upd_taken;
    logic [PC_BITS-1:0]                   upd_dest;
    logic                                 upd_ready;
    logic                                 err;

    modport slave (
        input  br_valid_in, br_wid_in, br_taken_in, br_dest_in,
        input  issue_valid, issue_wid, upd_ready,
        output stalled_mask, upd_valid, upd_wid, upd_taken, upd_dest, err
    );

    modport master (
        output br_valid_in, br_wid_in, br_taken_in, br_dest_in,
        output issue_valid, issue_wid, upd_ready,
        input  stalled_mask, upd_valid, upd_wid, upd_taken, upd_dest, err
    );

endinterface

// File: rtl/vx_branch_resolver_rr_arbiter.sv
// Round-robin pick among requesting warps; combinational grant, pointer advances to grant+1
// only on handshake, and the grant is locked while valid is held without ready.
module vx_branch_resolver_rr_arbiter
    import vx_branch_resolver_pkg::*;
#(
    parameter int N  = DEF_NUM_WARPS,
    parameter int NW = nw_width(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [NW-1:0] grant_o
);

    logic [NW-1:0] ptr_q, ptr_d;
    logic          lock_q, lock_d;
    logic [NW-1:0] lock_idx_q, lock_idx_d;
    logic [NW-1:0] rr_idx;
    logic [NW-1:0] cand_idx;
    logic          found;
    int            cand;

    always_comb begin
        rr_idx   = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= N) cand = cand - N;
            cand_idx = NW'(cand);
            if (!found && req_i[cand_idx]) begin
                found  = 1'b1;
                rr_idx = cand_idx;
            end
        end
    end

    // A held grant stays put so a newly ready warp cannot change the offered update.
    assign valid_o = |req_i;
    assign grant_o = lock_q ? lock_idx_q : rr_idx;

    always_comb begin
        ptr_d      = ptr_q;
        lock_d     = valid_o && !ready_i;
        lock_idx_d = grant_o;
        if (valid_o && ready_i) begin
            ptr_d = (grant_o == NW'(N - 1)) ? '0 : grant_o + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule

// File: rtl/vx_branch_resolver.sv
// Tracks outstanding branches per warp and returns resolved PCs to the scheduler one cycle after the report;
// reports/issues are never stalled, updates wait on upd_ready. BRANCH_RESOLVER_STATS_EN adds taken/not-taken counters.
module vx_branch_resolver
    import vx_branch_resolver_pkg::*;
#(
    parameter int NUM_BLOCKS = DEF_NUM_BLOCKS,
    parameter int NUM_WARPS  = DEF_NUM_WARPS
) (
    input  logic                     clk,
    input  logic                     reset,
    vx_branch_resolver_if.slave      bus
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    output logic [PERF_CTR_BITS-1:0] perf_taken,
    output logic [PERF_CTR_BITS-1:0] perf_not_taken
`endif
);

    localparam int NW_WIDTH = nw_width(NUM_WARPS);

    br_state_t            state_q [NUM_WARPS];
    br_state_t            state_d [NUM_WARPS];
    logic [NUM_WARPS-1:0] taken_q, taken_d;
    logic [PC_BITS-1:0]   dest_q  [NUM_WARPS];
    logic [PC_BITS-1:0]   dest_d  [NUM_WARPS];
    logic                 err_q, err_d;

    logic [NUM_WARPS-1:0] rep_hit;
    logic [NUM_WARPS-1:0] rep_taken;
    logic [PC_BITS-1:0]   rep_dest [NUM_WARPS];
    logic [NUM_WARPS-1:0] issue_hit;
    logic [NUM_WARPS-1:0] granted;
    logic [NUM_WARPS-1:0] done_req;
    logic                 dup_err;
    logic                 arb_valid;
    logic [NW_WIDTH-1:0]  grant_idx;
    logic                 upd_fire;

    // Lowest block index wins when several blocks name the same warp.
    always_comb begin
        rep_hit   = '0;
        rep_taken = '0;
        dup_err   = 1'b0;
        issue_hit = '0;
        granted   = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            rep_dest[w]  = '0;
            issue_hit[w] = bus.issue_valid && (bus.issue_wid == NW_WIDTH'(w));
            granted[w]   = upd_fire && (grant_idx == NW_WIDTH'(w));
            for (int b = 0; b < NUM_BLOCKS; b++) begin
                if (bus.br_valid_in[b] && (bus.br_wid_in[b] == NW_WIDTH'(w))) begin
                    if (rep_hit[w]) begin
                        dup_err = 1'b1;
                    end else begin
                        rep_hit[w]   = 1'b1;
                        rep_taken[w] = bus.br_taken_in[b];
                        rep_dest[w]  = bus.br_dest_in[b];
                    end
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        taken_d = taken_q;
        dest_d  = dest_q;
        err_d   = err_q | dup_err;
        for (int w = 0; w < NUM_WARPS; w++) begin
            case (state_q[w])
                IDLE: begin
                    if (issue_hit[w]) state_d[w] = WAIT;
                    if (rep_hit[w])   err_d      = 1'b1;
                end
                WAIT: begin
                    if (rep_hit[w]) begin
                        state_d[w] = DONE;
                        taken_d[w] = rep_taken[w];
                        dest_d[w]  = rep_dest[w];
                    end
                    if (issue_hit[w]) err_d = 1'b1;
                end
                DONE: begin
                    if (granted[w])        state_d[w] = issue_hit[w] ? WAIT : IDLE;
                    else if (issue_hit[w]) err_d      = 1'b1;
                    if (rep_hit[w])        err_d      = 1'b1;
                end
                default: state_d[w] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                state_q[w] <= IDLE;
                dest_q[w]  <= '0;
            end
            taken_q <= '0;
            err_q   <= 1'b0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                state_q[w] <= state_d[w];
                dest_q[w]  <= dest_d[w];
            end
            taken_q <= taken_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            done_req[w]         = (state_q[w] == DONE);
            bus.stalled_mask[w] = (state_q[w] != IDLE);
        end
    end

    vx_branch_resolver_rr_arbiter #(
        .N  (NUM_WARPS),
        .NW (NW_WIDTH)
    ) u_rr_arb (
        .clk     (clk),
        .reset   (reset),
        .req_i   (done_req),
        .ready_i (bus.upd_ready),
        .valid_o (arb_valid),
        .grant_o (grant_idx)
    );

    assign upd_fire      = arb_valid && bus.upd_ready;
    assign bus.upd_valid = arb_valid;
    assign bus.upd_wid   = arb_valid ? grant_idx : '0;
    assign bus.upd_taken = arb_valid && taken_q[grant_idx];
    assign bus.upd_dest  = arb_valid ? dest_q[grant_idx] : '0;
    assign bus.err       = err_q;

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [PERF_CTR_BITS-1:0] perf_taken_q, perf_not_taken_q;
    logic [PERF_CTR_BITS-1:0] n_taken, n_not_taken;

    always_comb begin
        n_taken     = '0;
        n_not_taken = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if ((state_q[w] == WAIT) && rep_hit[w]) begin
                if (rep_taken[w]) n_taken     = n_taken + 1'b1;
                else              n_not_taken = n_not_taken + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_taken_q     <= '0;
            perf_not_taken_q <= '0;
        end else begin
            perf_taken_q     <= perf_taken_q + n_taken;
            perf_not_taken_q <= perf_not_taken_q + n_not_taken;
        end
    end

    assign perf_taken     = perf_taken_q;
    assign perf_not_taken = perf_not_taken_q;
`endif

endmodule

// File: tb/tb_vx_branch_resolver.sv
// Directed bench for vx_branch_resolver: 2 blocks, 8 warps, expected values hand-computed per step.
module tb_vx_branch_resolver;
    import vx_branch_resolver_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    vx_branch_resolver_if #(.NUM_BLOCKS(2), .NUM_WARPS(8)) bus ();

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [PERF_CTR_BITS-1:0] perf_taken, perf_not_taken;
`endif

    vx_branch_resolver #(.NUM_BLOCKS(2), .NUM_WARPS(8)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef BRANCH_RESOLVER_STATS_EN
        ,
        .perf_taken     (perf_taken),
        .perf_not_taken (perf_not_taken)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.br_valid_in = '0;
        bus.issue_valid = 1'b0;
    endtask

    task automatic issue(input int w);
        bus.issue_valid = 1'b1;
        bus.issue_wid   = 3'(w);
        tick();
    endtask

    task automatic report(input int b, input int w, input logic t, input logic [31:0] d);
        bus.br_valid_in[b] = 1'b1;
        bus.br_wid_in[b]   = 3'(w);
        bus.br_taken_in[b] = t;
        bus.br_dest_in[b]  = d;
    endtask

    task automatic chk_upd(input string tag, input int w, input logic t, input logic [31:0] d);
        chk({tag, "_valid"}, bus.upd_valid, 1);
        chk({tag, "_wid"},   bus.upd_wid,   w);
        chk({tag, "_taken"}, bus.upd_taken, t);
        chk({tag, "_dest"},  bus.upd_dest,  d);
    endtask

    initial begin
        reset           = 1'b1;
        bus.br_valid_in = '0;
        bus.br_wid_in   = '0;
        bus.br_taken_in = '0;
        bus.br_dest_in  = '0;
        bus.issue_valid = 1'b0;
        bus.issue_wid   = '0;
        bus.upd_ready   = 1'b0;

        #3;
        chk("rst_stalled", bus.stalled_mask, 0);
        chk("rst_valid",   bus.upd_valid,    0);
        chk("rst_wid",     bus.upd_wid,      0);
        chk("rst_taken",   bus.upd_taken,    0);
        chk("rst_dest",    bus.upd_dest,     0);
        chk("rst_err",     bus.err,          0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Round-robin order from pointer 0, two blocks reporting distinct warps in one cycle.
        issue(1); issue(2); issue(5);
        chk("rr_stalled", bus.stalled_mask, 8'h26);
        report(0, 1, 1'b0, 32'h11); report(1, 2, 1'b1, 32'h22); tick();
        report(0, 5, 1'b1, 32'h55); tick();
        chk_upd("rr_g1", 1, 1'b0, 32'h11);
        bus.upd_ready = 1'b1;
        tick(); chk_upd("rr_g2", 2, 1'b1, 32'h22);
        tick(); chk_upd("rr_g5", 5, 1'b1, 32'h55);
        tick();
        chk("rr_idle_valid",   bus.upd_valid,    0);
        chk("rr_idle_stalled", bus.stalled_mask, 0);

        // Pointer now 6: warp 7 must win over warp 0, then wrap to 0.
        issue(0); issue(7);
        bus.upd_ready = 1'b0;
        report(0, 0, 1'b1, 32'hA0); report(1, 7, 1'b0, 32'h70); tick();
        chk_upd("wrap_g7", 7, 1'b0, 32'h70);
        bus.upd_ready = 1'b1;
        tick(); chk_upd("wrap_g0", 0, 1'b1, 32'hA0);
        tick(); chk("wrap_idle_valid", bus.upd_valid, 0);
`ifdef BRANCH_RESOLVER_STATS_EN
        chk("perf_taken_5",     perf_taken,     3);
        chk("perf_not_taken_5", perf_not_taken, 2);
`endif

        // Basic report-to-update latency.
        issue(3);
        chk("lat_stalled_wait", bus.stalled_mask, 8'h08);
        bus.upd_ready = 1'b0;
        report(0, 3, 1'b1, 32'h100); tick();
        chk_upd("lat", 3, 1'b1, 32'h100);
        chk("lat_stalled_done", bus.stalled_mask, 8'h08);
        bus.upd_ready = 1'b1;
        tick();
        chk("lat_stalled_clr", bus.stalled_mask, 0);
        chk("lat_valid_clr",   bus.upd_valid,    0);

        // Backpressure: warp 2 offered, warp 0 becomes DONE later and must not preempt.
        bus.upd_ready = 1'b0;
        issue(2); issue(0);
        report(0, 2, 1'b0, 32'h200); tick();
        chk_upd("bp_first", 2, 1'b0, 32'h200);
        report(1, 0, 1'b1, 32'h300); tick();
        for (int i = 0; i < 4; i++) begin
            chk_upd("bp_hold", 2, 1'b0, 32'h200);
            tick();
        end
        bus.upd_ready = 1'b1;
        chk_upd("bp_release", 2, 1'b0, 32'h200);
        tick(); chk_upd("bp_next", 0, 1'b1, 32'h300);
        tick();
        chk("bp_idle_valid", bus.upd_valid, 0);
        chk("bp_err_clean",  bus.err,       0);

        // Same warp reported by both blocks: block 0 wins, err set.
        issue(4);
        report(0, 4, 1'b1, 32'h10); report(1, 4, 1'b0, 32'h20); tick();
        chk_upd("dup", 4, 1'b1, 32'h10);
        chk("dup_err", bus.err, 1);
        tick();
        chk("dup_idle_valid", bus.upd_valid, 0);

        // Grant and reissue in the same cycle go straight back to WAIT.
        issue(6);
        report(0, 6, 1'b0, 32'h66); tick();
        chk_upd("reiss_done", 6, 1'b0, 32'h66);
        issue(6);
        chk("reiss_stalled", bus.stalled_mask, 8'h40);
        chk("reiss_valid",   bus.upd_valid,    0);
        report(0, 6, 1'b1, 32'h67); tick();
        chk_upd("reiss_second", 6, 1'b1, 32'h67);
        tick();
        chk("reiss_stalled_clr", bus.stalled_mask, 0);

        // Asynchronous reset mid-operation with three warps waiting.
        bus.upd_ready = 1'b0;
        issue(1); issue(2); issue(3);
        chk("mid_stalled", bus.stalled_mask, 8'h0E);
        #2 reset = 1'b1;
        #1;
        chk("arst_stalled", bus.stalled_mask, 0);
        chk("arst_err",     bus.err,          0);
        chk("arst_valid",   bus.upd_valid,    0);
`ifdef BRANCH_RESOLVER_STATS_EN
        chk("arst_perf_taken",     perf_taken,     0);
        chk("arst_perf_not_taken", perf_not_taken, 0);
`endif
        @(posedge clk);
        #1 reset = 1'b0;
        bus.upd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_valid",   bus.upd_valid,    0);
            chk("post_rst_stalled", bus.stalled_mask, 0);
            tick();
        end

        // Report to a warp left IDLE by reset is dropped and flags err.
        report(0, 1, 1'b1, 32'h1); tick();
        chk("idle_rep_err",     bus.err,          1);
        chk("idle_rep_valid",   bus.upd_valid,    0);
        chk("idle_rep_stalled", bus.stalled_mask, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
